// File: rtl/toy_dmem_if.sv
// Toy-bus data-memory port: LSU request channel plus read-ack channel.
// The master is the LSU; the slave is the memory responder.
interface toy_dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic                    mem_req_vld;
  logic                    mem_req_rdy;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [DATA_WIDTH/8-1:0] mem_req_strb;
  logic                    mem_req_opcode;
  logic                    mem_ack_vld;
  logic                    mem_ack_rdy;
  logic [DATA_WIDTH-1:0]   mem_ack_data;

  modport master (
    output mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode, mem_ack_rdy,
    input  mem_req_rdy, mem_ack_vld, mem_ack_data
  );

  modport slave (
    input  mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode, mem_ack_rdy,
    output mem_req_rdy, mem_ack_vld, mem_ack_data
  );
endinterface

// File: rtl/toy_dmem_resp.sv
// Data-memory responder: flop-array lines with byte-masked writes, one-cycle
// read acks through an output register plus skid, and a post-reset clear pass.
module toy_dmem_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 1024,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  toy_dmem_if.slave mem_if
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // toy_pack opcode encoding
  localparam logic TOY_BUS_READ  = 1'b0;
  localparam logic TOY_BUS_WRITE = 1'b1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        clr_idx_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;

  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [IDX_W-1:0]        req_idx;
  logic                    req_rdy;
  logic                    req_acc;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    consume;
  logic [DATA_WIDTH-1:0]   rd_line;
  logic                    unused_addr;

  assign req_addr    = mem_if.mem_req_addr;
  assign req_idx     = req_addr[LSB +: IDX_W];
  assign unused_addr = ^req_addr;

  assign req_rdy = (state_q == ST_RUN) && !skid_vld_q;
  assign req_acc = mem_if.mem_req_vld && req_rdy;
  assign rd_acc  = req_acc && (mem_if.mem_req_opcode == TOY_BUS_READ);
  assign wr_acc  = req_acc && (mem_if.mem_req_opcode == TOY_BUS_WRITE);
  assign consume = out_vld_q && mem_if.mem_ack_rdy;
  assign rd_line = mem_q[req_idx];

  assign mem_if.mem_req_rdy  = req_rdy;
  assign mem_if.mem_ack_vld  = out_vld_q;
  assign mem_if.mem_ack_data = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_CLEAR ? ST_INIT : ST_RUN;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // The array has no reset; the clear sequencer owns it while in INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_if.mem_req_strb[b]) begin
          mem_q[req_idx][8*b +: 8] <= mem_if.mem_req_data[8*b +: 8];
        end
      end
    end
  end

  // Output register refills from the skid first to keep acceptance order;
  // its data is only rewritten on a load so it holds after the ack.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (consume || !out_vld_q) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
      end else if (rd_acc) begin
        out_vld_d  = 1'b1;
        out_data_d = rd_line;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (rd_acc) begin
      skid_vld_d  = 1'b1;
      skid_data_d = rd_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end
endmodule

// File: tb/tb_toy_dmem_resp.sv
// Directed bench for toy_dmem_resp at DEPTH=16: clear, masked/null writes,
// streaming reads, back-pressure with skid, and reset during a stall.
module tb_toy_dmem_resp;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int DEPTH = 16;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_wait;

  logic [DW-1:0] line1, line2, line3, mw_exp, ones;

  toy_dmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  toy_dmem_resp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_CLEAR(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem_if(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s = %0h", tag, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic vld, input logic op, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    bus.mem_req_vld    = vld;
    bus.mem_req_opcode = op;
    bus.mem_req_addr   = addr;
    bus.mem_req_data   = data;
    bus.mem_req_strb   = strb;
  endtask

  task automatic idle();
    req(1'b0, RD, '0, '0, '0);
  endtask

  // Count cycles until ready rises, bounded.
  task automatic wait_rdy(output int n);
    n = 0;
    while (bus.mem_req_rdy !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    line1  = {8{32'h1111_1111}};
    line2  = {8{32'h2222_2222}};
    line3  = {8{32'h3333_3333}};
    ones   = '1;
    mw_exp = '0;
    mw_exp[63:32] = 32'hDEAD_BEEF;
    idle();
    bus.mem_ack_rdy = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_ack_vld", DW'(bus.mem_ack_vld), DW'(1'b0));
    chk("rst_ack_data", bus.mem_ack_data, '0);
    chk("rst_req_rdy", DW'(bus.mem_req_rdy), DW'(1'b0));

    // Clear: ready rises after exactly DEPTH cycles
    rst_n = 1'b1;
    wait_rdy(n_wait);
    chk("init_cycles", DW'(n_wait), DW'(DEPTH));
    req(1'b1, RD, 32'h1E0, '0, '0);
    step();
    chk("clr_ack_vld", DW'(bus.mem_ack_vld), DW'(1'b1));
    chk("clr_ack_data", bus.mem_ack_data, '0);

    // Masked write then read next cycle
    req(1'b1, WR, 32'h40, DW'(64'hDEAD_BEEF_0000_0000), 32'h0000_00F0);
    step();
    chk("wr_no_ack", DW'(bus.mem_ack_vld), DW'(1'b0));
    chk("wr_ack_data_hold", bus.mem_ack_data, '0);
    req(1'b1, RD, 32'h40, '0, '0);
    step();
    chk("mw_ack_vld", DW'(bus.mem_ack_vld), DW'(1'b1));
    chk("mw_ack_data", bus.mem_ack_data, mw_exp);

    // Null write leaves line unchanged
    req(1'b1, WR, 32'h40, ones, '0);
    step();
    chk("nw_no_ack", DW'(bus.mem_ack_vld), DW'(1'b0));
    req(1'b1, RD, 32'h40, '0, '0);
    step();
    chk("nw_ack_data", bus.mem_ack_data, mw_exp);

    // Fill lines 1..3, then stream reads
    req(1'b1, WR, 32'h20, line1, '1); step();
    req(1'b1, WR, 32'h40, line2, '1); step();
    req(1'b1, WR, 32'h60, line3, '1); step();
    req(1'b1, RD, 32'h20, '0, '0); step();
    chk("b2b_ack1", bus.mem_ack_data, line1);
    chk("b2b_rdy1", DW'(bus.mem_req_rdy), DW'(1'b1));
    req(1'b1, RD, 32'h40, '0, '0); step();
    chk("b2b_ack2", bus.mem_ack_data, line2);
    chk("b2b_vld2", DW'(bus.mem_ack_vld), DW'(1'b1));
    req(1'b1, RD, 32'h60, '0, '0); step();
    chk("b2b_ack3", bus.mem_ack_data, line3);
    chk("b2b_rdy3", DW'(bus.mem_req_rdy), DW'(1'b1));
    // Address beyond DEPTH lines wraps to line 1
    req(1'b1, RD, 32'h220, '0, '0); step();
    chk("wrap_ack", bus.mem_ack_data, line1);
    idle(); step();
    chk("b2b_drain_vld", DW'(bus.mem_ack_vld), DW'(1'b0));
    chk("b2b_drain_hold", bus.mem_ack_data, line1);

    // Back-pressure: A in output, B in skid
    bus.mem_ack_rdy = 1'b0;
    req(1'b1, RD, 32'h20, '0, '0); step();
    chk("bp_a_vld", DW'(bus.mem_ack_vld), DW'(1'b1));
    chk("bp_rdy_before_skid", DW'(bus.mem_req_rdy), DW'(1'b1));
    req(1'b1, RD, 32'h40, '0, '0); step();
    chk("bp_a_held", bus.mem_ack_data, line1);
    chk("bp_rdy_full", DW'(bus.mem_req_rdy), DW'(1'b0));
    // A write offered while the skid is full must not land
    req(1'b1, WR, 32'hA0, ones, '1); step();
    chk("bp_a_still", bus.mem_ack_data, line1);
    idle();
    bus.mem_ack_rdy = 1'b1;
    step();
    chk("bp_b_vld", DW'(bus.mem_ack_vld), DW'(1'b1));
    chk("bp_b_data", bus.mem_ack_data, line2);
    chk("bp_rdy_back", DW'(bus.mem_req_rdy), DW'(1'b1));
    step();
    chk("bp_done_vld", DW'(bus.mem_ack_vld), DW'(1'b0));
    req(1'b1, RD, 32'hA0, '0, '0); step();
    chk("bp_stalled_wr", bus.mem_ack_data, '0);
    idle(); step();

    // Reset during a full-skid stall
    bus.mem_ack_rdy = 1'b0;
    req(1'b1, RD, 32'h20, '0, '0); step();
    req(1'b1, RD, 32'h40, '0, '0); step();
    idle();
    chk("pre_rst_full", DW'(bus.mem_req_rdy), DW'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_vld", DW'(bus.mem_ack_vld), DW'(1'b0));
    step(); step();
    rst_n = 1'b1;
    bus.mem_ack_rdy = 1'b1;
    wait_rdy(n_wait);
    chk("reinit_cycles", DW'(n_wait), DW'(DEPTH));
    req(1'b1, RD, 32'h20, '0, '0); step();
    chk("reinit_vld", DW'(bus.mem_ack_vld), DW'(1'b1));
    chk("reinit_data", bus.mem_ack_data, '0);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
